// File: rtl/hsc_usb_pkg.sv
// Shared encodings and constants for the FX3 slave-FIFO test source:
// pattern modes, pattern seeds, LFSR taps and the transmit FSM states.
package hsc_usb_pkg;

  typedef enum logic [1:0] {
    MODE_INC  = 2'b00,
    MODE_WALK = 2'b01,
    MODE_ALT  = 2'b10,
    MODE_LFSR = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } tx_state_e;

  localparam logic [31:0] SEED_INC   = 32'h0000_0000;
  localparam logic [31:0] SEED_WALK  = 32'h0000_0001;
  localparam logic [31:0] SEED_ALT   = 32'h5555_5555;
  localparam logic [31:0] SEED_LFSR  = 32'hFFFF_FFFF;
  // Galois taps for x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0] LFSR_TAPS  = 32'h8020_0003;

  function automatic logic [31:0] seedFor(input mode_e mode);
    logic [31:0] seed;
    unique case (mode)
      MODE_INC:  seed = SEED_INC;
      MODE_WALK: seed = SEED_WALK;
      MODE_ALT:  seed = SEED_ALT;
      default:   seed = SEED_LFSR;
    endcase
    return seed;
  endfunction

endpackage

// File: rtl/usb_tx_source_if.sv
// Valid/ready word stream from the test source into the FX3 write side.
interface usb_tx_source_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_last;
  logic              tx_ready;

  modport master (output tx_data, output tx_valid, output tx_last, input tx_ready);
  modport slave  (input tx_data, input tx_valid, input tx_last, output tx_ready);
endinterface

// File: rtl/usb_pattern_gen.sv
// Test-pattern register: loads the seed of the selected mode and steps to
// the next pattern word each time a word is accepted.
module usb_pattern_gen
  import hsc_usb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_advance,
  input  mode_e       i_mode,
  output logic [31:0] o_word
);

  logic [31:0] r_word;
  logic [31:0] w_next;

  always_comb begin
    w_next = r_word;
    unique case (i_mode)
      MODE_INC:  w_next = r_word + 32'd1;
      MODE_WALK: w_next = {r_word[30:0], r_word[31]};
      MODE_ALT:  w_next = ~r_word;
      default:   w_next = r_word[0] ? ((r_word >> 1) ^ LFSR_TAPS) : (r_word >> 1);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word <= '0;
    end else if (i_load) begin
      r_word <= seedFor(i_mode);
    end else if (i_advance) begin
      r_word <= w_next;
    end
  end

  assign o_word = r_word;

endmodule

// File: rtl/usb_tx_source.sv
// Burst packet source for the FX3 write path: fixed-length packets of
// test-pattern words with tx_last on the final word and optional idle gaps.
module usb_tx_source
  import hsc_usb_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int PKT_WORDS  = 256,
  parameter int GAP_CYCLES = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_enable,
  input  logic [1:0]       i_mode,
  input  logic [CNT_W-1:0] i_pkt_num,
  usb_tx_source_if.master  tx,
  output logic             o_busy,
  output logic             o_done,
  output logic [CNT_W-1:0] o_pkt_cnt
);

  localparam int WCNT_W     = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
  localparam int GCNT_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int GAP_LAST_I = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(PKT_WORDS - 1);
  localparam logic [GCNT_W-1:0] GAP_LAST  = GCNT_W'(GAP_LAST_I);

  tx_state_e         r_state;
  tx_state_e         w_next;
  mode_e             r_mode;
  logic [CNT_W-1:0]  r_pktNum;
  logic [CNT_W-1:0]  r_pktCnt;
  logic [WCNT_W-1:0] r_wordCnt;
  logic [GCNT_W-1:0] r_gapCnt;

  logic              w_start;
  logic              w_accept;
  logic              w_isLast;
  logic              w_burstEnd;
  logic              w_gapEnd;
  logic [CNT_W-1:0]  w_pktCntInc;
  mode_e             w_genMode;
  logic [31:0]       w_word;

  // The seed is loaded in the same edge that latches mode, so IDLE feeds the live input.
  assign w_genMode = (r_state == ST_IDLE) ? mode_e'(i_mode) : r_mode;

  usb_pattern_gen u_pattern (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_start),
    .i_advance (w_accept),
    .i_mode    (w_genMode),
    .o_word    (w_word)
  );

  always_comb begin
    w_next      = r_state;
    w_start     = 1'b0;
    w_accept    = 1'b0;
    w_isLast    = (r_wordCnt == LAST_WORD);
    w_pktCntInc = (r_pktCnt == '1) ? r_pktCnt : r_pktCnt + 1'b1;
    w_burstEnd  = ((r_pktNum != '0) && (w_pktCntInc == r_pktNum)) || !i_enable;
    w_gapEnd    = (r_gapCnt == GAP_LAST);
    unique case (r_state)
      ST_IDLE: begin
        if (i_enable) begin
          w_start = 1'b1;
          w_next  = ST_SEND;
        end
      end
      ST_SEND: begin
        w_accept = tx.tx_ready;
        if (w_accept && w_isLast) begin
          if (w_burstEnd)           w_next = ST_DONE;
          else if (GAP_CYCLES == 0) w_next = ST_SEND;
          else                      w_next = ST_GAP;
        end
      end
      ST_GAP: begin
        if (w_gapEnd) w_next = i_enable ? ST_SEND : ST_DONE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_mode    <= MODE_INC;
      r_pktNum  <= '0;
      r_pktCnt  <= '0;
      r_wordCnt <= '0;
      r_gapCnt  <= '0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_mode    <= mode_e'(i_mode);
        r_pktNum  <= i_pkt_num;
        r_pktCnt  <= '0;
        r_wordCnt <= '0;
      end else if (w_accept) begin
        r_wordCnt <= w_isLast ? '0 : r_wordCnt + 1'b1;
        if (w_isLast) r_pktCnt <= w_pktCntInc;
      end
      r_gapCnt <= (r_state == ST_GAP) ? r_gapCnt + 1'b1 : '0;
    end
  end

  assign tx.tx_valid = (r_state == ST_SEND);
  assign tx.tx_last  = (r_state == ST_SEND) && w_isLast;
  assign tx.tx_data  = (r_state == ST_SEND) ? DATA_W'(w_word) : '0;
  assign o_busy      = (r_state != ST_IDLE);
  assign o_done      = (r_state == ST_DONE);
  assign o_pkt_cnt   = r_pktCnt;

endmodule

// File: tb/tb_usb_tx_source.sv
// Randomised scoreboard bench for usb_tx_source: expected words and packet
// counts are queued per burst and consumed by an independent stream monitor.
module tb_usb_tx_source;

  localparam int DATA_W     = 32;
  localparam int PKT_WORDS  = 4;
  localparam int GAP_CYCLES = 2;
  localparam int CNT_W      = 3;
  localparam int MAX_CNT    = (1 << CNT_W) - 1;
  // x^32 + x^22 + x^2 + x^1 terms of the feedback polynomial
  localparam logic [31:0] POLY_TAPS = (32'h1 << 31) | (32'h1 << 21) | (32'h1 << 1) | 32'h1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             enable = 1'b0;
  logic [1:0]       mode = 2'b00;
  logic [CNT_W-1:0] pktNum = '0;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] pktCnt;

  usb_tx_source_if #(.DATA_W(DATA_W)) txIf ();

  usb_tx_source #(
    .DATA_W     (DATA_W),
    .PKT_WORDS  (PKT_WORDS),
    .GAP_CYCLES (GAP_CYCLES),
    .CNT_W      (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_enable  (enable),
    .i_mode    (mode),
    .i_pkt_num (pktNum),
    .tx        (txIf),
    .o_busy    (busy),
    .o_done    (done),
    .o_pkt_cnt (pktCnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } word_t;

  word_t wordQ[$];
  int    cntQ[$];
  int    checks = 0;
  int    errors = 0;
  int    gapRun = 0;
  bit    gapArmed = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic failNow(input string name, input string why);
    checks++;
    errors++;
    $display("[TB] FAIL %s: %s", name, why);
  endtask

  function automatic logic [31:0] lfsrStep(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ POLY_TAPS) : (s >> 1);
  endfunction

  // Whole-burst expectation from the pattern definitions, indexed by word number.
  function automatic void pushBurst(input int m, input int packets);
    logic [31:0] lfsr = 32'hFFFF_FFFF;
    word_t w;
    for (int n = 0; n < packets * PKT_WORDS; n++) begin
      case (m)
        0:       w.data = 32'(n);
        1:       w.data = 32'h1 << (n % 32);
        2:       w.data = (n % 2 == 0) ? 32'h5555_5555 : 32'hAAAA_AAAA;
        default: begin w.data = lfsr; lfsr = lfsrStep(lfsr); end
      endcase
      w.last = ((n % PKT_WORDS) == PKT_WORDS - 1);
      wordQ.push_back(w);
    end
  endfunction

  initial begin
    word_t exp;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        gapArmed = 1'b0;
      end else begin
        if (done) begin
          gapArmed = 1'b0;
          if (cntQ.size() == 0) failNow("unexpected_done", "done pulse with no burst pending");
          else checkOutput("pkt_cnt_at_done", 32'(pktCnt), 32'(cntQ.pop_front()));
          checkOutput("busy_in_done", 32'(busy), 32'd1);
          checkOutput("words_left_at_done", 32'(wordQ.size()), 32'd0);
        end else if (gapArmed) begin
          if (txIf.tx_valid) begin
            checkOutput("gap_len", 32'(gapRun), 32'(GAP_CYCLES));
            gapArmed = 1'b0;
          end else begin
            gapRun++;
          end
        end
        if (txIf.tx_valid && txIf.tx_ready) begin
          if (wordQ.size() == 0) begin
            failNow("unexpected_word", $sformatf("extra word 0x%08h", txIf.tx_data));
          end else begin
            exp = wordQ.pop_front();
            checkOutput("tx_data", txIf.tx_data, exp.data);
            checkOutput("tx_last", 32'(txIf.tx_last), 32'(exp.last));
            if (exp.last) begin
              gapArmed = 1'b1;
              gapRun   = 0;
            end
          end
        end
      end
    end
  end

  // One burst: hold keeps enable high until done, otherwise enable drops after
  // dropAfter accepted words; abortCycles > 0 hits reset mid-burst instead.
  task automatic applyStimulus(input int m, input int pn, input bit hold, input int dropAfter,
                               input int readyMode, input int abortCycles);
    int packets, acc, cyc;
    bit seenDone;
    bit readyPat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    packets = (dropAfter + PKT_WORDS - 1) / PKT_WORDS;
    if (packets < 1) packets = 1;
    if (hold) packets = pn;
    else if (pn != 0 && pn < packets) packets = pn;
    cyc = 0;
    while (busy && cyc < 200) begin @(negedge clk); cyc++; end
    if (busy) begin
      failNow("idle_timeout", "DUT never returned to idle");
      return;
    end
    pushBurst(m, packets);
    cntQ.push_back(packets > MAX_CNT ? MAX_CNT : packets);
    mode   = 2'(m);
    pktNum = CNT_W'(pn);
    enable = 1'b1;
    txIf.tx_ready = 1'b1;
    @(negedge clk);
    acc = 0;
    cyc = 0;
    seenDone = 1'b0;
    while (!seenDone && cyc < 2000) begin
      if (done) begin
        seenDone = 1'b1;
        enable   = 1'b0;
      end else begin
        if (!hold && acc >= dropAfter) enable = 1'b0;
        mode   = 2'($urandom);
        pktNum = CNT_W'($urandom);
        case (readyMode)
          0:       txIf.tx_ready = 1'b1;
          1:       txIf.tx_ready = readyPat[cyc % 4];
          default: txIf.tx_ready = ($urandom_range(0, 3) != 0);
        endcase
        if (abortCycles != 0 && cyc == abortCycles) begin
          #3 rst = 1'b1;
          #1;
          checkOutput("rst_tx_valid", 32'(txIf.tx_valid), 32'd0);
          checkOutput("rst_busy", 32'(busy), 32'd0);
          checkOutput("rst_pkt_cnt", 32'(pktCnt), 32'd0);
          checkOutput("rst_tx_data", txIf.tx_data, 32'd0);
          wordQ.delete();
          cntQ.delete();
          enable = 1'b0;
          @(negedge clk);
          rst = 1'b0;
          txIf.tx_ready = 1'b1;
          return;
        end
        if (txIf.tx_valid && txIf.tx_ready) acc++;
        @(negedge clk);
        cyc++;
      end
    end
    if (!seenDone) failNow("burst_timeout", "no done pulse within 2000 cycles");
    txIf.tx_ready = 1'b1;
  endtask

  initial begin
    txIf.tx_ready = 1'b1;
    rst = 1'b1;
    #12;
    checkOutput("reset_tx_valid", 32'(txIf.tx_valid), 32'd0);
    checkOutput("reset_tx_last", 32'(txIf.tx_last), 32'd0);
    checkOutput("reset_tx_data", txIf.tx_data, 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_pkt_cnt", 32'(pktCnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(0, 2, 1'b1, 0, 0, 0);
    applyStimulus(0, 2, 1'b0, 0, 0, 0);
    applyStimulus(0, 2, 1'b1, 0, 1, 0);
    applyStimulus(3, 1, 1'b1, 0, 2, 0);
    applyStimulus(1, 1, 1'b1, 0, 2, 0);
    applyStimulus(2, 1, 1'b1, 0, 2, 0);
    applyStimulus(0, 0, 1'b0, 9, 0, 0);
    applyStimulus(0, 0, 1'b0, 4, 0, 0);
    applyStimulus(1, 0, 1'b0, 38, 2, 0);
    applyStimulus(0, 3, 1'b1, 0, 0, 7);
    applyStimulus(0, 1, 1'b1, 0, 0, 0);

    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 1) == 1)
        applyStimulus($urandom_range(0, 3), $urandom_range(1, MAX_CNT), 1'b1, 0, 2, 0);
      else
        applyStimulus($urandom_range(0, 3), 0, 1'b0, $urandom_range(0, 33), 2, 0);
    end

    repeat (5) @(negedge clk);
    checkOutput("queues_drained", 32'(wordQ.size() + cntQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
